// File: rtl/data_mem_slave.sv
// rtl/data_mem_slave.sv - fixed-latency word-addressed data memory slave
//
// A single-port memory window that answers one request at a time. A request is
// captured when accepted, counted down for LAT cycles, then completed with a
// one-cycle m_ready pulse. Writes and the read-data register both take effect
// on the edge that enters RESP, so data and error are stable for the whole
// pulse.
//
// Ports:
//   clk       in   1   clock, rising edge
//   rst       in   1   synchronous reset, active high
//   m_a       in  32   byte address
//   m_din     in  32   write data
//   m_dout    out 32   read data register (held between reads)
//   m_strobe  in   1   request valid
//   m_rw      in   1   0 = read, 1 = write
//   m_wen     in   4   byte enables, bit n covers [8n+7:8n]
//   m_size    in   2   0 = byte, 1 = half, 2 = word, 3 = reserved
//   m_ready   out  1   completion pulse
//   m_err     out  1   error flag, meaningful only with m_ready
//   stall     in   1   freezes the latency countdown

module data_mem_slave #(
    parameter int          AW   = 10,
    parameter int          LAT  = 2,
    parameter logic [31:0] BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m_a,
    input  logic [31:0] m_din,
    output logic [31:0] m_dout,
    input  logic        m_strobe,
    input  logic        m_rw,
    input  logic [3:0]  m_wen,
    input  logic [1:0]  m_size,
    output logic        m_ready,
    output logic        m_err,
    input  logic        stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0]  CNT_INIT = 4'(LAT - 1);
    // Clears the offset bits inside the 4*2^AW byte window.
    localparam logic [31:0] WIN_MASK = ~((32'd1 << (AW + 2)) - 32'd1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] a_q,     a_d;
    logic [31:0] din_q,   din_d;
    logic [3:0]  wen_q,   wen_d;
    logic [1:0]  size_q,  size_d;
    logic        rw_q,    rw_d;
    logic        err_q;
    logic [31:0] dout_q;

    // Set for exactly the cycle whose closing edge enters RESP.
    logic        complete;

    logic          in_window;
    logic          misaligned;
    logic          req_err;
    logic [AW-1:0] word_idx;

    logic [31:0] mem [2**AW];

    // Request classification works entirely from the captured copy, so input
    // changes after acceptance cannot affect the outcome.
    always_comb begin
        in_window  = ((a_q & WIN_MASK) == BASE);
        misaligned = ((size_q == 2'd1) && a_q[0])
                  || ((size_q == 2'd2) && (a_q[1:0] != 2'b00))
                  ||  (size_q == 2'd3);
        req_err    = !in_window || misaligned;
        word_idx   = a_q[AW+1:2];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        din_d    = din_q;
        wen_d    = wen_q;
        size_d   = size_q;
        rw_d     = rw_q;
        complete = 1'b0;

        case (state_q)
            IDLE: begin
                if (m_strobe) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                    a_d     = m_a;
                    din_d   = m_din;
                    wen_d   = m_wen;
                    size_d  = m_size;
                    rw_d    = m_rw;
                end
            end
            WAIT: begin
                // Stall also holds a counter already at zero.
                if (!stall) begin
                    if (cnt_q == 4'd0) begin
                        state_d  = RESP;
                        complete = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            din_q   <= 32'd0;
            wen_q   <= 4'd0;
            size_q  <= 2'd0;
            rw_q    <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            din_q   <= din_d;
            wen_q   <= wen_d;
            size_q  <= size_d;
            rw_q    <= rw_d;
            if (complete) begin
                err_q <= req_err;
                // Errored requests of either direction clear the read data;
                // valid writes leave it untouched.
                if (req_err) begin
                    dout_q <= 32'd0;
                end else if (!rw_q) begin
                    dout_q <= mem[word_idx];
                end
            end
        end
    end

    // Storage has no reset. The rst term keeps a reset that lands on the
    // completing edge from committing the write.
    always_ff @(posedge clk) begin
        if (!rst && complete && rw_q && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wen_q[b]) begin
                    mem[word_idx][8*b +: 8] <= din_q[8*b +: 8];
                end
            end
        end
    end

    assign m_ready = (state_q == RESP);
    assign m_err   = m_ready && err_q;
    assign m_dout  = dout_q;

endmodule
